fft_peak_interp_feeder: RTL
===========================

Name: fft_peak_interp_feeder

Overview:
Streaming stage directly upstream of the fixed-point divider in the FFT post-process chain.
- Scans each frame of NBINS FFT magnitudes for the peak bin k.
- Forms the parabolic-interpolation numerator |m[k+1]-m[k-1]| and denominator 2*(2m[k]-m[k-1]-m[k+1]) as unsigned fixed-point words.
- Issues them to the divider with a one-cycle valid strobe, gated by the divider's ready. Bin index and sign travel as side info.

Parameters:
MAG_W, 16, magnitude input width (unsigned)
NBINS, 256, bins per frame (>=3)
IDX_W, $clog2(NBINS), bin index width
DIV_WI, MAG_W+4, integer bits of dividend/divisor words (MSB always 0)
DIV_WF, 8, fraction bits of dividend/divisor words (always zero)

Ports:
clk  in  1  clock
rstn  in  1  reset
s_vld  in  1  magnitude sample valid; input is never stalled
s_mag  in  MAG_W  magnitude sample, bin order 0..NBINS-1
d_vld  out  1  one-cycle request to divider
d_dividend  out  DIV_WI+DIV_WF  |num| << DIV_WF
d_divisor  out  DIV_WI+DIV_WF  den << DIV_WF
d_ready  in  1  divider ready (not busy)
p_vld  out  1  one-cycle strobe: side info valid (same cycle as d_vld, or alone if flat)
p_bin  out  IDX_W  peak bin k
p_neg  out  1  num < 0 (interpolated offset is negative)
p_flat  out  1  den == 0; no divider request issued
ovf  out  1  sticky: frame result dropped because previous one not yet issued

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. Reset applies at any point, including mid-frame or with a result pending.
  - All outputs are 0, the bin counter is 0, the window is cleared, the pending slot is empty, the FSM is in IDLE.
  - A partial frame is discarded.
- Bin counter: increments on each s_vld and wraps NBINS-1 -> 0. The sample at count NBINS-1 is the frame's last.
- Window: holds left, centre and right samples.
  - On sample i (i>=1), centre = bin i-1, left = m[i-2], right = m[i]. Out-of-frame neighbours read as 0.
  - Bin 0 is evaluated when sample 1 arrives. Bin NBINS-1 is evaluated the cycle after the last sample (flush, right = 0).
- Peak rule:
  - Bin 0 always initialises best.
  - A later centre replaces best only if strictly greater. Ties keep the first occurrence.
  - On capture, left, centre, right and k are stored.
- Arithmetic, registered on the flush cycle +1:
  - num = r - l, signed MAG_W+1.
  - den = 2*(2c - l - r), MAG_W+3 bits, always >= 0 by the peak rule.
  - dividend = zero-extended |num|, divisor = den, each then shifted left DIV_WF.
- Issue FSM:
  - IDLE -> PEND when a result is latched into the pending slot.
  - PEND with p_flat: p_vld=1 for 1 cycle, d_vld stays 0, -> IDLE.
  - PEND with d_ready=1: d_vld=p_vld=1 for exactly 1 cycle, d_dividend/d_divisor/p_* valid that cycle and held afterwards, -> IDLE.
  - PEND with d_ready=0: wait.
- Latency: last sample at cycle t -> flush t+1 -> pending latched t+2 -> d_vld at t+2 at the earliest, if d_ready=1.
- Overflow: a new result arriving while PEND drops the new result and sets ovf=1; the old result is kept. ovf clears only on reset.
- Scanning continues during PEND, so frames are back-to-back with no gaps required.

Optional Feature:
PEAK_MIN_THR_EN
- When defined: adds input port thr [MAG_W-1:0]. If the peak centre c < thr, the result is treated like flat (p_vld with p_flat=1, no d_vld).
- When undefined: no thr port; only den==0 yields flat.

Decomposition:
- Package fft_post_pkg holds: MAG_W/NBINS defaults, IDX_W function, the issue FSM state enum (IDLE, PEND), and a peak_t struct {l, c, r, bin}.
- Sub-module peak_window_tracker: counter, window, best capture, and frame-end pulse with peak_t output. The top holds the arithmetic, pending slot and FSM.

Test Plan:
- NBINS=8, d_ready=1, frame [0,1,3,10,6,2,0,0]: d_vld once, p_bin=3, p_neg=0, d_dividend=3<<8, d_divisor=22<<8, 2 cycles after the last sample.
- Frame [9,4,0,0,0,0,0,0]: p_bin=0, left=0, dividend=4<<8, divisor=28<<8. Frame [0,0,0,0,0,0,1,7]: p_bin=7, right=0, p_neg=1, dividend=1<<8, divisor=26<<8.
- Tie frame [0,5,5,0,0,0,0,0]: p_bin=1, dividend=5<<8, divisor=10<<8. All-zero frame: p_vld with p_flat=1, no d_vld.
- d_ready=0 across two back-to-back frames: ovf=1, and on d_ready rising exactly one d_vld carries the first frame's values.
- rstn low one cycle after 4 samples, then a clean frame [0,1,3,10,6,2,0,0]: single result p_bin=3, no ovf, no spurious strobe.
- With PEAK_MIN_THR_EN and thr=11 on the first frame: p_flat=1, no d_vld. With thr=10: normal issue.

Source files
------------

// File: rtl/fft_peak_interp_feeder_pkg.sv
// fft_post_pkg: shared defaults, issue FSM states and peak record for the FFT post-process chain
package fft_post_pkg;
  localparam int MAG_W_DEF = 16;
  localparam int NBINS_DEF = 256;
  localparam int DIV_WF = 8;
  localparam int PK_MAG_W = 32;
  localparam int PK_IDX_W = 16;
  function automatic int idx_w(input int nbins);
    return $clog2(nbins);
  endfunction
  typedef enum logic {IDLE, PEND} st_t;
  // fields sized for the widest supported build; users narrow them with casts
  typedef struct packed {
    logic [PK_MAG_W-1:0] l;
    logic [PK_MAG_W-1:0] c;
    logic [PK_MAG_W-1:0] r;
    logic [PK_IDX_W-1:0] bin;
  } peak_t;
endpackage

// File: rtl/fft_peak_interp_feeder_if.sv
// fft_peak_interp_feeder_if: magnitude stream in, divider request and peak side info out
interface fft_peak_interp_feeder_if import fft_post_pkg::*; #(
  parameter int MAG_W = MAG_W_DEF,
  parameter int NBINS = NBINS_DEF
);
  localparam int IDX_W = idx_w(NBINS);
  localparam int DW = MAG_W + 4 + DIV_WF;
  logic s_vld;
  logic [MAG_W-1:0] s_mag;
  logic d_vld;
  logic [DW-1:0] d_dividend;
  logic [DW-1:0] d_divisor;
  logic d_ready;
  logic p_vld;
  logic [IDX_W-1:0] p_bin;
  logic p_neg;
  logic p_flat;
  logic ovf;
  modport master (
    input s_vld, s_mag, d_ready,
    output d_vld, d_dividend, d_divisor, p_vld, p_bin, p_neg, p_flat, ovf
  );
  modport slave (
    output s_vld, s_mag, d_ready,
    input d_vld, d_dividend, d_divisor, p_vld, p_bin, p_neg, p_flat, ovf
  );
endinterface

// File: rtl/fft_peak_interp_feeder_tracker.sv
// peak_window_tracker: bin counter, 3-sample window and first-max capture with a frame-end pulse
module peak_window_tracker import fft_post_pkg::*; #(
  parameter int MAG_W = MAG_W_DEF,
  parameter int NBINS = NBINS_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vld,
  input  logic [MAG_W-1:0] i_mag,
  output logic             o_done,
  output peak_t            o_pk
);
  localparam int IDX_W = idx_w(NBINS);
  logic [IDX_W-1:0] r_cnt;
  logic [MAG_W-1:0] r_p1, r_p2;
  logic r_flush;
  peak_t r_best;
  peak_t w_cand;
  logic w_take;
  // the flush cycle evaluates the last bin with a zero right neighbour
  always_comb begin
    w_cand.l = PK_MAG_W'((r_flush || r_cnt > IDX_W'(1)) ? r_p2 : MAG_W'(0));
    w_cand.c = PK_MAG_W'(r_p1);
    w_cand.r = PK_MAG_W'(r_flush ? MAG_W'(0) : i_mag);
    w_cand.bin = PK_IDX_W'(r_flush ? IDX_W'(NBINS - 1) : r_cnt - 1'b1);
  end
  assign w_take = r_cnt == IDX_W'(1) || w_cand.c > r_best.c;
  assign o_done = r_flush;
  assign o_pk = w_take ? w_cand : r_best;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
      r_flush <= 1'b0;
      r_best <= '0;
    end else begin
      r_flush <= i_vld && r_cnt == IDX_W'(NBINS - 1);
      if (i_vld) begin
        r_cnt <= r_cnt == IDX_W'(NBINS - 1) ? '0 : r_cnt + 1'b1;
        r_p2 <= r_p1;
        r_p1 <= i_mag;
        if (r_cnt != '0 && w_take) r_best <= w_cand;
      end
    end
  end
endmodule

// File: rtl/fft_peak_interp_feeder.sv
// fft_peak_interp_feeder: peak search plus parabolic-interpolation operands for the divider
// PEAK_MIN_THR_EN adds i_thr: peaks whose centre is below it are reported as flat
module fft_peak_interp_feeder import fft_post_pkg::*; #(
  parameter int MAG_W = MAG_W_DEF,
  parameter int NBINS = NBINS_DEF
) (
  input logic clk,
  input logic rstn,
`ifdef PEAK_MIN_THR_EN
  input logic [MAG_W-1:0] i_thr,
`endif
  fft_peak_interp_feeder_if.master io
);
  localparam int IDX_W = idx_w(NBINS);
  localparam int DW = MAG_W + 4 + DIV_WF;
  peak_t w_pk;
  logic w_done;
  logic [MAG_W-1:0] w_l, w_c, w_r;
  logic signed [MAG_W:0] w_num;
  logic [MAG_W:0] w_abs;
  logic [MAG_W+2:0] w_den;
  logic w_flat;
  st_t r_st;
  logic [DW-1:0] r_dvd, r_dvs;
  logic [IDX_W-1:0] r_bin;
  logic r_neg, r_flat, r_ovf;
  peak_window_tracker #(.MAG_W(MAG_W), .NBINS(NBINS)) u_trk (
    .clk(clk), .rstn(rstn), .i_vld(io.s_vld), .i_mag(io.s_mag), .o_done(w_done), .o_pk(w_pk)
  );
  assign w_l = MAG_W'(w_pk.l);
  assign w_c = MAG_W'(w_pk.c);
  assign w_r = MAG_W'(w_pk.r);
  assign w_num = $signed({1'b0, w_r}) - $signed({1'b0, w_l});
  assign w_abs = w_num[MAG_W] ? $unsigned(-w_num) : $unsigned(w_num);
  // cannot go negative: the centre is the frame maximum
  assign w_den = {1'b0, w_c, 2'b0} - {2'b0, w_l, 1'b0} - {2'b0, w_r, 1'b0};
`ifdef PEAK_MIN_THR_EN
  assign w_flat = w_den == '0 || w_c < i_thr;
`else
  assign w_flat = w_den == '0;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_st <= IDLE;
      r_dvd <= '0;
      r_dvs <= '0;
      r_bin <= '0;
      r_neg <= 1'b0;
      r_flat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_done && r_st == PEND) r_ovf <= 1'b1;
      if (w_done && r_st == IDLE) begin
        r_dvd <= DW'({w_abs, {DIV_WF{1'b0}}});
        r_dvs <= DW'({w_den, {DIV_WF{1'b0}}});
        r_bin <= IDX_W'(w_pk.bin);
        r_neg <= w_num[MAG_W];
        r_flat <= w_flat;
        r_st <= PEND;
      end else if (r_st == PEND && (r_flat || io.d_ready)) r_st <= IDLE;
    end
  end
  assign io.d_vld = r_st == PEND && !r_flat && io.d_ready;
  assign io.p_vld = r_st == PEND && (r_flat || io.d_ready);
  assign io.d_dividend = r_dvd;
  assign io.d_divisor = r_dvs;
  assign io.p_bin = r_bin;
  assign io.p_neg = r_neg;
  assign io.p_flat = r_flat;
  assign io.ovf = r_ovf;
endmodule
